// File: rtl/global_pkg.sv
// Shared definitions for the UART/RAM subsystem.
// Holds the RAM geometry, the DMA controller state encoding, its default
// region placement, and a constant function that validates a region layout.
package global_pkg;

  // gp_ram has an 8-bit address, so the full space is usable.
  localparam int unsigned RAM_DEPTH = 256;

  // Default DMA region placement.
  localparam logic [7:0]  DMA_RX_BASE = 8'h10;
  localparam int unsigned DMA_RX_LEN  = 8;
  localparam logic [7:0]  DMA_TX_BASE = 8'h04;
  localparam int unsigned DMA_TX_LEN  = 2;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RX_REQ   = 4'd1,
    RX_WRITE = 4'd2,
    RX_GAP   = 4'd3,
    TX_REQ   = 4'd4,
    TX_READ  = 4'd5,
    TX_LATCH = 4'd6,
    TX_WAIT  = 4'd7,
    TX_BUSY  = 4'd8,
    DONE     = 4'd9
  } dma_state_t;

  // True when both regions fit in RAM, are legally sized and do not overlap.
  function automatic bit dma_regions_ok(input int unsigned rx_base, input int unsigned rx_len,
                                        input int unsigned tx_base, input int unsigned tx_len);
    bit ok;
    ok = (rx_len >= 1) && (rx_len <= 64) && (tx_len >= 1) && (tx_len <= 8);
    ok = ok && (rx_base + rx_len <= RAM_DEPTH) && (tx_base + tx_len <= RAM_DEPTH);
    ok = ok && ((rx_base + rx_len <= tx_base) || (tx_base + tx_len <= rx_base));
    return ok;
  endfunction

endpackage

// File: rtl/dma_ctrl.sv
// Bus-master DMA between the UART stage and gp_ram.
//  - RX path: pops bytes from the RX buffer into a circular RAM region.
//  - TX path: on Send_comm, reads TX_LEN bytes from the TX region and hands
//    them one by one to the UART transmitter.
// The RAM port is driven only while the CPU grants the bus (DMA_RQ/DMA_ACK).
//
// Ports:
//   Clk, Rst_n          clock, synchronous active-low reset
//   RCVD_Data, RX_Empty RX buffer head byte and empty flag
//   Data_Read           one-cycle pop strobe to the RX buffer
//   TX_Data, Valid_D    byte to transmitter and its one-cycle valid strobe
//   TX_RDY              transmitter idle
//   Send_comm           CPU start-transmit pulse
//   READY               no transmit active or pending
//   DMA_RQ, DMA_ACK     bus request / grant
//   Ram_*               gp_ram master port (Ram_Rdata is registered by the RAM)
module dma_ctrl
  import global_pkg::*;
#(
  parameter logic [7:0]  RX_BASE = DMA_RX_BASE,
  parameter int unsigned RX_LEN  = DMA_RX_LEN,
  parameter logic [7:0]  TX_BASE = DMA_TX_BASE,
  parameter int unsigned TX_LEN  = DMA_TX_LEN
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] RCVD_Data,
  input  logic       RX_Empty,
  output logic       Data_Read,
  output logic [7:0] TX_Data,
  output logic       Valid_D,
  input  logic       TX_RDY,
  input  logic       Send_comm,
  output logic       READY,
  output logic       DMA_RQ,
  input  logic       DMA_ACK,
  output logic       Ram_Cs,
  output logic       Ram_Wen,
  output logic       Ram_Oen,
  output logic [7:0] Ram_Addr,
  output logic [7:0] Ram_Wdata,
  input  logic [7:0] Ram_Rdata
);

  if (!dma_regions_ok(RX_BASE, RX_LEN, TX_BASE, TX_LEN)) begin : g_cfg_check
    $error("dma_ctrl: invalid RX/TX region layout");
  end

  localparam logic [5:0] RxLast = 6'(RX_LEN - 1);
  localparam logic [2:0] TxLast = 3'(TX_LEN - 1);

  dma_state_t r_state, w_state_nxt;
  logic [5:0] r_wptr, w_wptr_nxt;
  logic [2:0] r_tx_idx, w_tx_idx_nxt;
  logic       r_send_pend, w_send_pend_nxt;
  logic [7:0] r_tx_data, w_tx_data_nxt;
  logic       r_valid, w_valid_nxt;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_tx_idx    <= '0;
      r_send_pend <= 1'b0;
      r_tx_data   <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wptr      <= w_wptr_nxt;
      r_tx_idx    <= w_tx_idx_nxt;
      r_send_pend <= w_send_pend_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wptr_nxt      = r_wptr;
    w_tx_idx_nxt    = r_tx_idx;
    w_tx_data_nxt   = r_tx_data;
    w_valid_nxt     = 1'b0;
    w_send_pend_nxt = r_send_pend;

    unique case (r_state)
      IDLE: begin
        // RX wins so the RX buffer never backs up behind a TX burst.
        if (!RX_Empty)        w_state_nxt = RX_REQ;
        else if (r_send_pend) w_state_nxt = TX_REQ;
      end
      RX_REQ:   if (DMA_ACK) w_state_nxt = RX_WRITE;
      RX_WRITE: begin
        w_wptr_nxt  = (r_wptr == RxLast) ? '0 : r_wptr + 6'd1;
        w_state_nxt = RX_GAP;
      end
      // One idle cycle so RX_Empty reflects the pop before deciding.
      RX_GAP:   w_state_nxt = RX_Empty ? IDLE : RX_WRITE;
      TX_REQ:   if (DMA_ACK) w_state_nxt = TX_READ;
      TX_READ:  w_state_nxt = TX_LATCH;
      TX_LATCH: begin
        w_tx_data_nxt = Ram_Rdata;
        w_state_nxt   = TX_WAIT;
      end
      TX_WAIT: begin
        if (TX_RDY) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = TX_BUSY;
        end
      end
      // Wait for the transmitter to accept the byte (TX_RDY falls).
      TX_BUSY: begin
        if (!TX_RDY) begin
          if (r_tx_idx == TxLast) begin
            w_tx_idx_nxt = '0;
            w_state_nxt  = DONE;
          end else begin
            w_tx_idx_nxt = r_tx_idx + 3'd1;
            w_state_nxt  = TX_READ;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if ((w_state_nxt == TX_REQ) && (r_state != TX_REQ)) w_send_pend_nxt = 1'b0;
    // A pulse landing on the consume cycle is a fresh request, so it wins.
    if (Send_comm) w_send_pend_nxt = 1'b1;
  end

  always_comb begin
    DMA_RQ    = 1'b0;
    Data_Read = 1'b0;
    Ram_Cs    = 1'b0;
    Ram_Wen   = 1'b0;
    Ram_Oen   = 1'b0;
    Ram_Addr  = '0;
    Ram_Wdata = '0;

    case (r_state)
      RX_REQ, TX_REQ, TX_LATCH, TX_WAIT, TX_BUSY: DMA_RQ = 1'b1;
      RX_WRITE: begin
        DMA_RQ    = 1'b1;
        Ram_Cs    = 1'b1;
        Ram_Wen   = 1'b1;
        Ram_Addr  = RX_BASE + {2'b00, r_wptr};
        Ram_Wdata = RCVD_Data;
        Data_Read = 1'b1;
      end
      // Release the bus in the last cycle before returning to IDLE.
      RX_GAP: DMA_RQ = !RX_Empty;
      TX_READ: begin
        DMA_RQ   = 1'b1;
        Ram_Cs   = 1'b1;
        Ram_Oen  = 1'b1;
        Ram_Addr = TX_BASE + {5'b00000, r_tx_idx};
      end
      default: ;
    endcase
  end

  assign READY   = (r_state == IDLE) && !r_send_pend;
  assign TX_Data = r_tx_data;
  assign Valid_D = r_valid;

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: RX buffer, CPU arbiter, gp_ram and UART
// transmitter models around the DUT, with a reference model of RX region
// contents and the transmitted byte stream.
module tb_dma_ctrl;

  localparam logic [7:0]  RxBase   = 8'h10;
  localparam int          RxLen    = 8;
  localparam logic [7:0]  TxBase   = 8'h04;
  localparam int          TxLen    = 2;
  localparam logic [31:0] ResetVec = 32'h4000_0000;  // only READY set

  logic       Clk, Rst_n;
  logic [7:0] RCVD_Data;
  logic       RX_Empty, Data_Read;
  logic [7:0] TX_Data;
  logic       Valid_D, TX_RDY, Send_comm, READY, DMA_RQ, DMA_ACK;
  logic       Ram_Cs, Ram_Wen, Ram_Oen;
  logic [7:0] Ram_Addr, Ram_Wdata, Ram_Rdata;

  dma_ctrl #(
    .RX_BASE(RxBase),
    .RX_LEN (RxLen),
    .TX_BASE(TxBase),
    .TX_LEN (TxLen)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .RCVD_Data(RCVD_Data),
    .RX_Empty (RX_Empty),
    .Data_Read(Data_Read),
    .TX_Data  (TX_Data),
    .Valid_D  (Valid_D),
    .TX_RDY   (TX_RDY),
    .Send_comm(Send_comm),
    .READY    (READY),
    .DMA_RQ   (DMA_RQ),
    .DMA_ACK  (DMA_ACK),
    .Ram_Cs   (Ram_Cs),
    .Ram_Wen  (Ram_Wen),
    .Ram_Oen  (Ram_Oen),
    .Ram_Addr (Ram_Addr),
    .Ram_Wdata(Ram_Wdata),
    .Ram_Rdata(Ram_Rdata)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // RX buffer: bench appends to rx_src, DUT pops via Data_Read.
  logic [7:0] rx_src [0:1023];
  int         rx_wr_cnt;
  int         rx_rd_cnt;
  assign RX_Empty  = (rx_rd_cnt == rx_wr_cnt);
  assign RCVD_Data = rx_src[rx_rd_cnt[9:0]];
  always @(posedge Clk) if (Data_Read) rx_rd_cnt <= rx_rd_cnt + 1;

  // CPU arbiter: grants grant_delay cycles after DMA_RQ, holds while requested.
  int grant_delay;
  int rq_age;
  always @(posedge Clk) begin
    if (!DMA_RQ) begin
      rq_age  <= 0;
      DMA_ACK <= 1'b0;
    end else begin
      rq_age <= rq_age + 1;
      if (rq_age + 1 >= grant_delay) DMA_ACK <= 1'b1;
    end
  end

  // UART transmitter: busy for busy_cycles after each accepted byte.
  int   busy_cycles;
  int   tx_cnt;
  logic hold_tx;
  assign TX_RDY = (tx_cnt == 0) && !hold_tx;
  always @(posedge Clk) begin
    if (Valid_D)         tx_cnt <= busy_cycles;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end

  // gp_ram: registered read, zero the cycle after a non-read.
  logic [7:0] mem      [0:255];
  bit         written  [0:255];
  logic [7:0] init_img [0:255];
  always @(posedge Clk) begin
    if (Ram_Cs && Ram_Wen) begin
      mem[Ram_Addr]     <= Ram_Wdata;
      written[Ram_Addr] <= 1'b1;
    end
    if (Ram_Cs && Ram_Oen) Ram_Rdata <= written[Ram_Addr] ? mem[Ram_Addr] : init_img[Ram_Addr];
    else                   Ram_Rdata <= 8'h00;
  end

  function automatic bit in_rx(input logic [7:0] a);
    return (int'(a) >= int'(RxBase)) && (int'(a) < int'(RxBase) + RxLen);
  endfunction

  function automatic bit in_tx(input logic [7:0] a);
    return (int'(a) >= int'(TxBase)) && (int'(a) < int'(TxBase) + TxLen);
  endfunction

  // Bus monitor, sampled mid-cycle.
  int         cyc;
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         wr_cyc_q  [$];
  logic [7:0] rd_addr_q [$];
  int         rd_cyc_q  [$];
  logic [7:0] tx_q      [$];
  int         dr_cnt, rq_rise, bad_bus, bad_valid, bad_dr;
  logic       valid_prev, rq_prev;
  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (Ram_Cs && Ram_Wen) begin
      wr_addr_q.push_back(Ram_Addr);
      wr_data_q.push_back(Ram_Wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (Ram_Cs && Ram_Oen) begin
      rd_addr_q.push_back(Ram_Addr);
      rd_cyc_q.push_back(cyc);
    end
    if ((Ram_Cs && Ram_Wen && (Ram_Oen || !in_rx(Ram_Addr))) ||
        (Ram_Cs && Ram_Oen && !in_tx(Ram_Addr)) ||
        (Ram_Cs && !(DMA_RQ && DMA_ACK)) ||
        (!Ram_Cs && (Ram_Wen || Ram_Oen || Ram_Addr != 8'h00 || Ram_Wdata != 8'h00)))
      bad_bus <= bad_bus + 1;
    if (Valid_D) tx_q.push_back(TX_Data);
    if (Valid_D && valid_prev) bad_valid <= bad_valid + 1;
    valid_prev <= Valid_D;
    if (Data_Read) dr_cnt <= dr_cnt + 1;
    if (Data_Read && RX_Empty) bad_dr <= bad_dr + 1;
    if (DMA_RQ && !rq_prev) rq_rise <= rq_rise + 1;
    rq_prev <= DMA_RQ;
  end

  // Reference model: RX ring contents and the expected transmitted stream.
  logic [7:0] exp_rx [0:RxLen-1];
  int         rx_total;
  int         pushed_total;
  logic [7:0] exp_tx [$];

  int n_checks, n_errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {1'b0, READY, DMA_RQ, Data_Read, Valid_D, Ram_Cs, Ram_Wen, Ram_Oen,
            Ram_Addr, Ram_Wdata, TX_Data};
  endfunction

  task automatic push_rx(input logic [7:0] b);
    rx_src[rx_wr_cnt[9:0]] = b;
    rx_wr_cnt++;
    exp_rx[rx_total % RxLen] = b;
    rx_total++;
    pushed_total++;
  endtask

  task automatic pulse_send();
    Send_comm = 1'b1;
    @(negedge Clk);
    Send_comm = 1'b0;
  endtask

  // A send issued with nothing pending produces one full burst of the TX image.
  task automatic send_burst();
    for (int k = 0; k < TxLen; k++) exp_tx.push_back(init_img[int'(TxBase) + k]);
    pulse_send();
  endtask

  task automatic dut_reset_pulse();
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n    = 1'b1;
    rx_total = 0;
  endtask

  task automatic wait_quiet(input string tag, input int bound);
    int n;
    n = 0;
    repeat (2) @(negedge Clk);
    while (!(RX_Empty && READY && !DMA_RQ && TX_RDY) && n < bound) begin
      @(negedge Clk);
      n++;
    end
    check_val({tag, "_timeout"}, 32'(n < bound), 32'd1);
  endtask

  initial begin
    int         b_w, b_r, b_dr, b_rise, b_tx, n;
    logic [7:0] v;
    Rst_n        = 1'b0;
    Send_comm    = 1'b0;
    hold_tx      = 1'b0;
    busy_cycles  = 5;
    grant_delay  = 2;
    rx_wr_cnt    = 0;
    rx_total     = 0;
    pushed_total = 0;
    n_checks     = 0;
    n_errors     = 0;
    for (int i = 0; i < 256; i++) init_img[i] = 8'($urandom);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check_val("reset_idle", outs_vec(), ResetVec);
    end

    // Two RX bytes in one bus tenure.
    b_w = wr_addr_q.size(); b_dr = dr_cnt; b_rise = rq_rise;
    push_rx(8'hA5);
    push_rx(8'h3C);
    wait_quiet("rx2", 200);
    check_val("rx2_mem10", 32'(mem[8'h10]), 32'h0000_00A5);
    check_val("rx2_mem11", 32'(mem[8'h11]), 32'h0000_003C);
    check_val("rx2_data_read", 32'(dr_cnt - b_dr), 32'd2);
    check_val("rx2_writes", 32'(wr_addr_q.size() - b_w), 32'd2);
    check_val("rx2_one_tenure", 32'(rq_rise - b_rise), 32'd1);

    // Ring wrap: 10 bytes into an 8-byte region from a fresh pointer.
    dut_reset_pulse();
    for (int i = 0; i < 10; i++) begin
      push_rx(8'(i));
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    wait_quiet("wrap", 400);
    for (int k = 0; k < RxLen; k++)
      check_val("wrap_region", 32'(mem[8'(int'(RxBase) + k)]), 32'(exp_rx[k]));
    b_w = wr_addr_q.size();
    push_rx(8'($urandom));
    wait_quiet("wptr", 100);
    if (wr_addr_q.size() > b_w)
      check_val("wptr_next_addr", 32'(wr_addr_q[b_w]), 32'(int'(RxBase) + ((rx_total - 1) % RxLen)));
    else check_val("wptr_write_seen", 32'(wr_addr_q.size() - b_w), 32'd1);

    // Basic TX burst.
    init_img[4] = 8'h55;
    init_img[5] = 8'hAA;
    busy_cycles = 5;
    b_tx = tx_q.size();
    send_burst();
    wait_quiet("tx", 400);
    check_val("tx_count", 32'(tx_q.size() - b_tx), 32'(TxLen));
    if (tx_q.size() >= b_tx + 2) begin
      check_val("tx_byte0", 32'(tx_q[b_tx]), 32'h0000_0055);
      check_val("tx_byte1", 32'(tx_q[b_tx + 1]), 32'h0000_00AA);
    end
    check_val("tx_ready_after", 32'(READY), 32'd1);

    // RX priority over a simultaneous send; re-sends mid-burst give one more burst.
    b_w = wr_addr_q.size(); b_r = rd_addr_q.size(); b_tx = tx_q.size();
    push_rx(8'($urandom));
    send_burst();
    n = 0;
    while (tx_q.size() == b_tx && n < 300) begin
      @(negedge Clk);
      n++;
    end
    check_val("prio_first_valid", 32'(n < 300), 32'd1);
    send_burst();
    @(negedge Clk);
    pulse_send();
    wait_quiet("prio", 800);
    if (wr_addr_q.size() > b_w && rd_addr_q.size() > b_r)
      check_val("prio_rx_first", 32'(wr_cyc_q[b_w] < rd_cyc_q[b_r]), 32'd1);
    else check_val("prio_accesses_seen", 32'd0, 32'd1);
    check_val("prio_tx_count", 32'(tx_q.size() - b_tx), 32'(2 * TxLen));

    // Reset while waiting on the transmitter for byte 0.
    hold_tx = 1'b1;
    b_r = rd_addr_q.size(); b_tx = tx_q.size();
    pulse_send();
    n = 0;
    while (rd_addr_q.size() == b_r && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check_val("abort_read_seen", 32'(n < 100), 32'd1);
    repeat (2) @(negedge Clk);
    dut_reset_pulse();
    check_val("abort_reset_vals", outs_vec(), ResetVec);
    hold_tx = 1'b0;
    repeat (20) @(negedge Clk);
    check_val("abort_no_valid", 32'(tx_q.size() - b_tx), 32'd0);
    b_r = rd_addr_q.size();
    send_burst();
    wait_quiet("abort_resend", 400);
    if (rd_addr_q.size() > b_r) check_val("abort_restart_addr", 32'(rd_addr_q[b_r]), 32'(TxBase));
    else check_val("abort_restart_read", 32'd0, 32'd1);
    check_val("abort_resend_count", 32'(tx_q.size() - b_tx), 32'(TxLen));

    // Random mix of RX traffic and sends, grant and transmitter timing.
    for (int it = 0; it < 40; it++) begin
      grant_delay = $urandom_range(1, 4);
      busy_cycles = $urandom_range(1, 6);
      case ($urandom_range(0, 2))
        0: repeat ($urandom_range(1, 4)) begin
          push_rx(8'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge Clk);
        end
        1: if (READY) begin
          for (int k = 0; k < TxLen; k++) init_img[int'(TxBase) + k] = 8'($urandom);
          send_burst();
        end
        default: begin
          v = 8'($urandom);
          push_rx(v);
          if (READY) send_burst();
        end
      endcase
      repeat ($urandom_range(0, 10)) @(negedge Clk);
    end
    wait_quiet("rand", 2000);

    // Global comparisons against the reference model.
    for (int k = 0; k < RxLen; k++)
      check_val("final_region", 32'(mem[8'(int'(RxBase) + k)]), 32'(exp_rx[k]));
    check_val("final_tx_len", 32'(tx_q.size()), 32'(exp_tx.size()));
    n = 0;
    for (int k = 0; k < exp_tx.size() && k < tx_q.size(); k++)
      if (tx_q[k] !== exp_tx[k]) n++;
    check_val("final_tx_bytes_bad", 32'(n), 32'd0);
    check_val("final_pops", 32'(dr_cnt), 32'(pushed_total));
    check_val("final_bus_protocol", 32'(bad_bus), 32'd0);
    check_val("final_valid_pulse", 32'(bad_valid), 32'd0);
    check_val("final_pop_empty", 32'(bad_dr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
